// File: rtl/prog_timer.sv
// Programmable down-counting timer with prescaler, periodic or one-shot operation.
// Emits a registered one-cycle tick each time a period expires.
module prog_timer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned PERIOD_INIT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PscLast = PW'(PRESCALE - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             tick_q, tick_d;
  logic             period_zero;

  assign period_zero = (period_q == '0);
  // start samples period_q, so a same-edge load only takes effect afterwards
  assign period_d    = load ? period_in : period_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    psc_d   = psc_q;
    tick_d  = 1'b0;
    if (stop) begin
      state_d = StIdle;
      count_d = '0;
      psc_d   = '0;
    end else if (start) begin
      // a start with a zero period is dropped and freezes everything this edge
      if (!period_zero) begin
        state_d = StRun;
        count_d = period_q - 1'b1;
        psc_d   = '0;
      end
    end else if (state_q == StRun && en) begin
      if (psc_q != PscLast) begin
        psc_d = psc_q + 1'b1;
      end else begin
        psc_d = '0;
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          tick_d = 1'b1;
          if (!mode && !period_zero) begin
            count_d = period_q - 1'b1;
          end else begin
            state_d = StIdle;
            count_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      period_q <= WIDTH'(PERIOD_INIT);
      psc_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      psc_q    <= psc_d;
      tick_q   <= tick_d;
    end
  end

  assign tick  = tick_q;
  assign busy  = (state_q == StRun);
  assign count = count_q;

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: two instances (PRESCALE 1 and 4) share stimulus,
// a reference model predicts each edge and a monitor compares.
module tb_prog_timer;

  localparam int W = 16;

  typedef struct packed {
    logic         tick;
    logic         busy;
    logic [W-1:0] count;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, load = 1'b0, mode = 1'b0, start = 1'b0, stop = 1'b0;
  logic [W-1:0] period_in = '0;
  logic         tick0, busy0, tick1, busy1;
  logic [W-1:0] count0, count1;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt0 = 0;
  int tick_cnt1 = 0;

  obs_t exp_q0[$];
  obs_t exp_q1[$];
  obs_t e0, e1;

  // model state per instance: running flag, counter, prescale phase, period, tick
  int m_run[2], m_cnt[2], m_ph[2], m_per[2], m_tick[2];

  always #5 clk = ~clk;

  prog_timer #(.WIDTH(W), .PRESCALE(1), .PERIOD_INIT(10)) u_p1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .period_in(period_in), .mode(mode),
    .start(start), .stop(stop), .tick(tick0), .busy(busy0), .count(count0)
  );

  prog_timer #(.WIDTH(W), .PRESCALE(4), .PERIOD_INIT(10)) u_p4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .period_in(period_in), .mode(mode),
    .start(start), .stop(stop), .tick(tick1), .busy(busy1), .count(count1)
  );

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic obs_t mk(input int t, input int r, input int c);
    obs_t o;
    o.tick  = (t != 0);
    o.busy  = (r != 0);
    o.count = W'(c);
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_cnt[i] = 0; m_ph[i] = 0; m_per[i] = 10; m_tick[i] = 0;
    end
  endtask

  // One rising edge of the abstract timer: pre enabled cycles make one step,
  // every P steps the period expires.
  task automatic model_edge(input int i, input int pre);
    m_tick[i] = 0;
    if (stop) begin
      m_run[i] = 0; m_cnt[i] = 0; m_ph[i] = 0;
    end else if (start) begin
      if (m_per[i] != 0) begin
        m_run[i] = 1; m_cnt[i] = m_per[i] - 1; m_ph[i] = 0;
      end
    end else if (m_run[i] != 0 && en) begin
      if (m_ph[i] < pre - 1) begin
        m_ph[i]++;
      end else begin
        m_ph[i] = 0;
        if (m_cnt[i] > 0) begin
          m_cnt[i]--;
        end else begin
          m_tick[i] = 1;
          if (!mode && m_per[i] != 0) m_cnt[i] = m_per[i] - 1;
          else begin m_run[i] = 0; m_cnt[i] = 0; end
        end
      end
    end
    if (load) m_per[i] = int'(period_in);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_edge(0, 1);
      model_edge(1, 4);
    end
    exp_q0.push_back(mk(m_tick[0], m_run[0], m_cnt[0]));
    exp_q1.push_back(mk(m_tick[1], m_run[1], m_cnt[1]));
    @(negedge clk);
    start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_p1", {tick0, busy0, count0}, '0);
    check("async_rst_p4", {tick1, busy1, count1}, '0);
    cycle();
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (tick0) tick_cnt0++;
    if (tick1) tick_cnt1++;
    if (exp_q0.size() != 0) begin
      e0 = exp_q0.pop_front();
      check("p1_outputs", {tick0, busy0, count0}, e0);
    end
    if (exp_q1.size() != 0) begin
      e1 = exp_q1.pop_front();
      check("p4_outputs", {tick1, busy1, count1}, e1);
    end
  end

  initial begin
    int base;
    model_reset();
    cycles(3);
    rst = 1'b0;
    cycles(4);

    // periodic, P=10: ticks at 10, 20, 30 edges after start
    en = 1'b1; mode = 1'b0;
    base = tick_cnt0;
    start = 1'b1;
    cycles(36);
    check("periodic_ticks", W'(tick_cnt0 - base), W'(3));

    // one-shot with P=5
    load = 1'b1; period_in = 5;
    cycle();
    mode = 1'b1; start = 1'b1;
    base = tick_cnt0;
    cycles(56);
    check("oneshot_ticks", W'(tick_cnt0 - base), W'(1));

    // prescaler 4 with P=3: ticks every 12 cycles, en gap delays by its length
    mode = 1'b0; load = 1'b1; period_in = 3;
    cycle();
    start = 1'b1;
    base = tick_cnt1;
    cycles(30);
    check("prescale_ticks", W'(tick_cnt1 - base), W'(2));
    cycles(3);
    en = 1'b0;
    cycles(7);
    en = 1'b1;
    cycles(30);

    // start+stop together, then mid-run load of 7 with P=10
    start = 1'b1; stop = 1'b1;
    cycles(3);
    load = 1'b1; period_in = 10;
    cycle();
    start = 1'b1;
    cycles(4);
    load = 1'b1; period_in = 7;
    cycles(25);

    // zero period is refused; period 1 ticks every step; zero reached mid-run stops
    stop = 1'b1;
    cycle();
    load = 1'b1; period_in = 0;
    cycle();
    start = 1'b1;
    cycles(5);
    load = 1'b1; period_in = 1;
    cycle();
    start = 1'b1;
    cycles(10);
    load = 1'b1; period_in = 0;
    cycles(10);

    // reset mid-count reverts the period to 10
    load = 1'b1; period_in = 6;
    cycle();
    start = 1'b1;
    cycles(3);
    async_reset();
    en = 1'b1; start = 1'b1;
    cycles(25);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom_range(0, 9) < 8);
      mode      = ($urandom_range(0, 9) < 3);
      start     = ($urandom_range(0, 99) < 5);
      stop      = ($urandom_range(0, 99) < 2);
      load      = ($urandom_range(0, 99) < 6);
      period_in = W'($urandom_range(0, 12));
      if ($urandom_range(0, 499) == 0) async_reset();
      else cycle();
    end

    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 Parameter WIDTH, default 16: width of period register and down-counter.
REQ-002 Parameter PRESCALE, default 1: clock cycles per counter step, legal range 1..65535.
REQ-003 Parameter PERIOD_INIT, default 10: period register value after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  step enable; low freezes prescaler and counter.
REQ-007 load  in  1  one-cycle strobe; capture period_in into the period register.
REQ-008 period_in  in  WIDTH  new period value P.
REQ-009 mode  in  1  0 = periodic, 1 = one-shot; sampled when each count reaches zero.
REQ-010 start  in  1  one-cycle strobe; arm or re-arm the timer.
REQ-011 stop  in  1  one-cycle strobe; abort the timer.
REQ-012 tick  out  1  registered one-cycle pulse at end of each period.
REQ-013 busy  out  1  high while in RUN.
REQ-014 count  out  WIDTH  current down-counter value.

Function
REQ-015 The block SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-016 A step SHALL occur on an edge where state=RUN, en=1 and prescaler=PRESCALE-1; the prescaler then wraps to 0, otherwise it increments while RUN and en=1.
REQ-017 With PRESCALE=1 the block SHALL step on every RUN cycle with en=1.
REQ-018 load SHALL update the period register on the same edge in any state; the counter is unaffected, and the new P applies from the next reload or start.
REQ-019 start with P!=0 and stop=0 SHALL set count=P-1, clear the prescaler, and enter RUN; this applies in IDLE and also as a restart from RUN.
REQ-020 start with P=0 SHALL be ignored: state, count and prescaler are unchanged.
REQ-021 If start and load occur on the same edge, start SHALL use the old P.
REQ-022 On a step with count>0 the block SHALL decrement count by 1 and hold tick=0.
REQ-023 On a step with count=0 the block SHALL assert tick=1 for exactly one clock.
REQ-024 On a count=0 step with mode=0 the block SHALL reload count=P-1, using the current period register, and stay in RUN.
REQ-025 On a count=0 step with P=0 in periodic mode the block SHALL return to IDLE.
REQ-026 On a count=0 step with mode=1 the block SHALL return to IDLE with count=0.
REQ-027 Tick timing: for PRESCALE=1 and en held high, the first tick SHALL occur in the cycle after the P-th edge following start, and subsequent ticks every P cycles.
REQ-028 General tick period SHALL be P*PRESCALE enabled cycles.
REQ-029 stop SHALL force IDLE, count=0 and prescaler=0 with no tick, and SHALL take priority over a simultaneous start or step.
REQ-030 en=0 SHALL hold count and prescaler and force tick=0; resuming en continues from the held values.
REQ-031 tick SHALL be 0 in every cycle that is not a count=0 step.
REQ-032 Counter arithmetic SHALL be unsigned modulo 2^WIDTH and SHALL never underflow, since zero always triggers reload or IDLE.

Reset
REQ-033 While rst is high, outputs and state SHALL be: state=IDLE, tick=0, busy=0, count=0, prescaler=0, period register=PERIOD_INIT.
REQ-034 Assertion of rst mid-RUN SHALL abort immediately, asynchronously, with no tick.
REQ-035 After rst deasserts, the block SHALL stay IDLE until a start strobe.

Verification
REQ-036 Periodic: PRESCALE=1, reset, start, mode=0, en=1 -> tick pulses at cycles 10, 20, 30 after start; count sequence 9..0; busy=1 throughout.
REQ-037 One-shot: load 5, mode=1, start -> a single tick 5 cycles later; busy falls with the tick; count=0; no further ticks for 50 cycles.
REQ-038 Prescaler: PRESCALE=4, P=3, periodic -> ticks every 12 cycles; toggling en low for 7 cycles delays the next tick by exactly 7 cycles.
REQ-039 Collisions: start+stop on the same edge -> IDLE, no tick; load 7 mid-run with P=10 -> current period ends at 10, the next period is 7.
REQ-040 Boundaries: load 0 then start -> busy stays 0; load 1, periodic -> tick every cycle; rst asserted mid-count -> outputs zero immediately and period reverts to PERIOD_INIT.
